// File: rtl/spi_seq_pkg.sv
// Shared types and width helpers for the SPI command sequencer.
package spi_seq_pkg;

    localparam int unsigned REG_WIDTH_DEF = 32;

    // Size field is wide enough to hold the value REG_WIDTH itself.
    function automatic int unsigned size_w(input int unsigned rw);
        return $clog2(rw) + 1;
    endfunction

    function automatic int unsigned entry_w(input int unsigned rw);
        return rw + size_w(rw);
    endfunction

    localparam int unsigned SIZE_W_DEF  = size_w(REG_WIDTH_DEF);
    localparam int unsigned ENTRY_W_DEF = entry_w(REG_WIDTH_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_GAP
    } seq_state_e;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Circular command buffer with wrap-around pointers and a separate occupancy count.
module spi_cmd_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 4
) (
    input  logic                   sys_clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Queues SPI transfer commands and issues them one at a time to spi_top,
// with an inter-transfer gap, a per-state watchdog and a completion counter.
module spi_cmd_sequencer
    import spi_seq_pkg::*;
#(
    parameter int REG_WIDTH      = 32,
    parameter int DEPTH          = 4,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       sys_clk,
    input  logic                       rstn,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [REG_WIDTH-1:0]       s_data,
    input  logic [$clog2(REG_WIDTH):0] s_size,
    input  logic                       cfg_cpol,
    input  logic                       cfg_cpha,
    output logic                       m_t_start,
    output logic [REG_WIDTH-1:0]       m_data_in,
    output logic [$clog2(REG_WIDTH):0] m_t_size,
    output logic                       m_cpol,
    output logic                       m_cpha,
    input  logic                       m_cs,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout_err,
    output logic [15:0]                xfer_count
);

    localparam int SW      = size_w(REG_WIDTH);
    localparam int EW      = entry_w(REG_WIDTH);
    localparam int CNT_TOP = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
    localparam int TW      = $clog2(CNT_TOP + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] CNT_SAT  = '1;

    seq_state_e            state;
    logic [TW-1:0]         tmo_cnt;
    logic [EW-1:0]         head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [SW-1:0]         head_size;
    logic [SW-1:0]         size_clamped;

    assign s_ready      = !fifo_full;
    assign busy         = (state != ST_IDLE) || (fifo_count != '0);
    assign head_size    = head[EW-1 -: SW];
    assign size_clamped = (head_size > SW'(REG_WIDTH)) ? SW'(REG_WIDTH) : head_size;

    spi_cmd_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .sys_clk   (sys_clk),
        .rstn      (rstn),
        .push      (s_valid && s_ready),
        .push_data ({s_size, s_data}),
        .pop       (state == ST_LOAD),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            m_t_start   <= 1'b0;
            m_data_in   <= '0;
            m_t_size    <= '0;
            m_cpol      <= 1'b0;
            m_cpha      <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            xfer_count  <= '0;
        end else begin
            m_t_start   <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            if (tmo_cnt != CNT_SAT) tmo_cnt <= tmo_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty && m_cs) begin
                        state   <= ST_LOAD;
                        tmo_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    tmo_cnt <= '0;
                    // Zero-length commands are dropped without touching the outputs.
                    if (head_size == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        m_data_in <= head[REG_WIDTH-1:0];
                        m_t_size  <= size_clamped;
                        m_cpol    <= cfg_cpol;
                        m_cpha    <= cfg_cpha;
                        m_t_start <= 1'b1;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    state   <= ST_WAIT_LO;
                    tmo_cnt <= '0;
                end
                ST_WAIT_LO: begin
                    if (!m_cs) begin
                        state   <= ST_WAIT_HI;
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ST_GAP;
                        tmo_cnt     <= '0;
                    end
                end
                ST_WAIT_HI: begin
                    if (m_cs) begin
                        done       <= 1'b1;
                        xfer_count <= xfer_count + 1'b1;
                        state      <= ST_GAP;
                        tmo_cnt    <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ST_GAP;
                        tmo_cnt     <= '0;
                    end
                end
                ST_GAP: begin
                    if (tmo_cnt == GAP_LAST) begin
                        state   <= ST_IDLE;
                        tmo_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer with a behavioural chip-select stub.
module tb_spi_cmd_sequencer;

    localparam int RW    = 32;
    localparam int SW    = 6;
    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam int TMO   = 256;

    logic          sys_clk = 1'b0;
    logic          rstn    = 1'b0;
    logic          s_valid;
    logic          s_ready;
    logic [RW-1:0] s_data;
    logic [SW-1:0] s_size;
    logic          cfg_cpol;
    logic          cfg_cpha;
    logic          m_t_start;
    logic [RW-1:0] m_data_in;
    logic [SW-1:0] m_t_size;
    logic          m_cpol;
    logic          m_cpha;
    logic          m_cs;
    logic          busy;
    logic          done;
    logic          timeout_err;
    logic [15:0]   xfer_count;

    always #5 sys_clk = ~sys_clk;

    spi_cmd_sequencer #(.REG_WIDTH(RW), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk(sys_clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_size(s_size), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
        .m_t_start(m_t_start), .m_data_in(m_data_in), .m_t_size(m_t_size),
        .m_cpol(m_cpol), .m_cpha(m_cpha), .m_cs(m_cs), .busy(busy), .done(done),
        .timeout_err(timeout_err), .xfer_count(xfer_count)
    );

    typedef struct {
        logic [RW-1:0] data;
        logic [SW-1:0] size;
        logic [1:0]    mode;
        int            start_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Slave stub: cs drops one cycle after t_start is seen and stays low size+1 cycles.
    logic [7:0] cs_cnt;
    logic       stub_dead = 1'b0;
    always @(posedge sys_clk or negedge rstn) begin
        if (!rstn)                       cs_cnt <= 8'd0;
        else if (m_t_start && !stub_dead) cs_cnt <= 8'(m_t_size) + 8'd2;
        else if (cs_cnt != 8'd0)         cs_cnt <= cs_cnt - 8'd1;
    end
    assign m_cs = !(cs_cnt != 8'd0 && cs_cnt <= 8'(m_t_size) + 8'd1);

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    int done_seen = 0, tmo_seen = 0, start_seen = 0;
    int last_start = 0, last_tmo = 0, last_rise = -1000;

    initial begin
        exp_t e;
        logic cs_prev;
        cs_prev = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (rstn) begin
                if (m_cs && !cs_prev) last_rise = cyc;
                cs_prev = m_cs;
                if (m_t_start) begin
                    start_seen++;
                    last_start = cyc;
                    if (exp_q.size() == 0) begin
                        bound_fail("unexpected_t_start");
                    end else begin
                        e = exp_q.pop_front();
                        check("start_data", m_data_in, e.data);
                        check("start_size", m_t_size, e.size);
                        check("start_mode", {m_cpol, m_cpha}, e.mode);
                        check("start_gap", (cyc - last_rise) >= GAP, 1);
                        if (e.start_cyc >= 0) check("start_latency", cyc, e.start_cyc);
                    end
                end
                if (done) begin
                    done_seen++;
                    check("done_after_cs_rise", cyc - last_rise, 1);
                end
                if (timeout_err) begin
                    tmo_seen++;
                    last_tmo = cyc;
                end
            end else begin
                cs_prev = 1'b1;
            end
        end
    end

    task automatic push_cmd(input logic [RW-1:0] d, input logic [SW-1:0] sz,
                            input logic [SW-1:0] exp_sz, input bit chk_lat);
        exp_t en;
        int n = 0;
        @(negedge sys_clk);
        s_valid = 1'b1;
        s_data  = d;
        s_size  = sz;
        while (!s_ready && n < 500) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= 500) bound_fail("push_ready");
        @(posedge sys_clk);
        #1;
        s_valid = 1'b0;
        if (exp_sz != 0) begin
            en.data      = d;
            en.size      = exp_sz;
            en.mode      = {cfg_cpol, cfg_cpha};
            en.start_cyc = chk_lat ? cyc + 2 : -1;
            exp_q.push_back(en);
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n = 0;
        while ((busy || !m_cs) && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= limit) bound_fail(name);
    endtask

    task automatic wait_cs_low(input string name, input int limit);
        int n = 0;
        while (m_cs && n < limit) begin
            @(negedge sys_clk);
            n++;
        end
        if (n >= limit) bound_fail(name);
    endtask

    initial begin
        int x0, d0, s0, t0;
        s_valid = 1'b0; s_data = '0; s_size = '0; cfg_cpol = 1'b0; cfg_cpha = 1'b0;
        rstn = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_t_start", m_t_start, 0);
        check("rst_data", m_data_in, 0);
        check("rst_size", m_t_size, 0);
        check("rst_mode", {m_cpol, m_cpha}, 0);
        check("rst_busy", busy, 0);
        check("rst_pulses", {done, timeout_err}, 0);
        check("rst_xfer_count", xfer_count, 0);
        rstn = 1'b1;

        // Single command
        push_cmd(32'hDEADBEEF, 6'd32, 6'd32, 1'b1);
        wait_idle("single_idle", 200);
        check("single_xfer_count", xfer_count, 1);
        check("single_done", done_seen, 1);
        check("single_start", start_seen, 1);

        // Back-to-back: the fifth push fills the FIFO because one pop overlapped
        x0 = xfer_count; d0 = done_seen;
        push_cmd(32'h0000CDEF, 6'd16, 6'd16, 1'b0);
        push_cmd(32'h00000067, 6'd8,  6'd8,  1'b0);
        push_cmd(32'h12345678, 6'd32, 6'd32, 1'b0);
        push_cmd(32'hFFFFFFFF, 6'd32, 6'd32, 1'b0);
        push_cmd(32'h00000000, 6'd32, 6'd32, 1'b0);
        @(negedge sys_clk);
        check("b2b_full_ready", s_ready, 0);
        wait_idle("b2b_idle", 1000);
        check("b2b_xfer_delta", xfer_count - x0, 5);
        check("b2b_done_delta", done_seen - d0, 5);

        // Mode change while the first transfer is in WAIT_HI
        push_cmd(32'hAAAA5555, 6'd32, 6'd32, 1'b0);
        wait_cs_low("mode_cs_low", 50);
        cfg_cpol = 1'b1; cfg_cpha = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("mode_hold", {m_cpol, m_cpha}, 2'b00);
        push_cmd(32'h5555AAAA, 6'd32, 6'd32, 1'b0);
        wait_idle("mode_idle", 300);
        check("mode_after_load", {m_cpol, m_cpha}, 2'b11);
        cfg_cpol = 1'b0; cfg_cpha = 1'b0;

        // Size edge cases
        x0 = xfer_count; d0 = done_seen; s0 = start_seen;
        push_cmd(32'h11111111, 6'd0, 6'd0, 1'b0);
        wait_idle("size0_idle", 100);
        check("size0_no_start", start_seen - s0, 0);
        check("size0_no_done", done_seen - d0, 0);
        push_cmd(32'hA5A5A5A5, 6'd40, 6'd32, 1'b0);
        wait_idle("clamp_idle", 200);
        check("clamp_t_size", m_t_size, 32);
        check("clamp_xfer_delta", xfer_count - x0, 1);

        // Watchdog: slave never responds
        stub_dead = 1'b1;
        x0 = xfer_count; t0 = tmo_seen;
        push_cmd(32'h0F0F0F0F, 6'd32, 6'd32, 1'b0);
        begin
            int n = 0;
            while (tmo_seen == t0 && n < 400) begin
                @(negedge sys_clk);
                n++;
            end
            if (n >= 400) bound_fail("timeout_wait");
        end
        check("timeout_count", tmo_seen - t0, 1);
        check("timeout_latency", last_tmo - last_start, TMO + 1);
        check("timeout_xfer_same", xfer_count, x0);
        wait_idle("timeout_idle", 50);
        stub_dead = 1'b0;
        push_cmd(32'h13579BDF, 6'd32, 6'd32, 1'b0);
        wait_idle("after_timeout_idle", 200);
        check("after_timeout_xfer", xfer_count - x0, 1);

        // Reset during WAIT_HI with two entries still queued
        push_cmd(32'hC0000001, 6'd32, 6'd32, 1'b0);
        push_cmd(32'hC0000002, 6'd32, 6'd32, 1'b0);
        push_cmd(32'hC0000003, 6'd32, 6'd32, 1'b0);
        wait_cs_low("rstmid_cs_low", 50);
        repeat (2) @(negedge sys_clk);
        #2 rstn = 1'b0;
        #1;
        check("rstmid_s_ready", s_ready, 1);
        check("rstmid_busy", busy, 0);
        check("rstmid_data", m_data_in, 0);
        check("rstmid_size", m_t_size, 0);
        check("rstmid_xfer_count", xfer_count, 0);
        check("rstmid_pulses", {m_t_start, done, timeout_err, m_cpol, m_cpha}, 0);
        exp_q.delete();
        d0 = done_seen; s0 = start_seen;
        @(negedge sys_clk);
        rstn = 1'b1;
        repeat (100) @(negedge sys_clk);
        check("rstmid_no_done", done_seen - d0, 0);
        check("rstmid_no_start", start_seen - s0, 0);
        check("rstmid_busy_after", busy, 0);

        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
